// File: rtl/pio_host_cmd.sv
// Host command responder for the PIO block: decodes the host bus into instruction-memory
// writes, per-SM configuration, control strobes and host-side TX/RX FIFO access.
module pio_host_cmd #(
    parameter int unsigned NSM        = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic                                clk_25mhz,
    input  logic                                reset,
    input  logic [$clog2(NSM)-1:0]              mindex,
    input  logic [31:0]                         din,
    input  logic [$clog2(IMEM_DEPTH)-1:0]       index,
    input  logic [5:0]                          action,
    output logic [31:0]                         dout,
    output logic [NSM-1:0]                      tx_full,
    output logic [NSM-1:0]                      rx_empty,
    input  logic [NSM*$clog2(IMEM_DEPTH)-1:0]   imem_raddr,
    output logic [NSM*16-1:0]                   imem_rdata,
    output logic [NSM*32-1:0]                   sm_clkdiv,
    output logic [NSM*32-1:0]                   sm_pinctrl,
    output logic [NSM*32-1:0]                   sm_execctrl,
    output logic [NSM*32-1:0]                   sm_shiftctrl,
    output logic [NSM-1:0]                      en_mask,
    output logic [NSM-1:0]                      restart,
    output logic [NSM-1:0]                      exec_valid,
    output logic [15:0]                         exec_instr,
    input  logic [NSM-1:0]                      sm_pull,
    output logic [NSM*32-1:0]                   sm_txdata,
    output logic [NSM-1:0]                      sm_txempty,
    input  logic [NSM-1:0]                      sm_push,
    input  logic [NSM*32-1:0]                   sm_rxdata,
    output logic [NSM-1:0]                      sm_rxfull
);
    localparam int unsigned MW = $clog2(NSM);
    localparam int unsigned IW = $clog2(IMEM_DEPTH);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [5:0] ActImem  = 6'd1;
    localparam logic [5:0] ActPush  = 6'd2;
    localparam logic [5:0] ActPop   = 6'd3;
    localparam logic [5:0] ActEn    = 6'd4;
    localparam logic [5:0] ActRst   = 6'd5;
    localparam logic [5:0] ActClk   = 6'd6;
    localparam logic [5:0] ActPin   = 6'd7;
    localparam logic [5:0] ActExecC = 6'd8;
    localparam logic [5:0] ActShift = 6'd9;
    localparam logic [5:0] ActExec  = 6'd10;

    logic [NSM-1:0] sel;
    always_comb begin
        sel = '0;
        for (int k = 0; k < NSM; k++) sel[k] = (mindex == MW'(k));
    end

    logic [15:0] imem_q [IMEM_DEPTH];
    always_ff @(posedge clk_25mhz) begin
        if (action == ActImem) imem_q[index] <= din[15:0];
    end

    logic [31:0] clkdiv_q [NSM];
    logic [31:0] pinctrl_q [NSM];
    logic [31:0] execctrl_q [NSM];
    logic [31:0] shiftctrl_q [NSM];
    logic [NSM-1:0] en_mask_q, restart_q, restart_d, exec_valid_q, exec_valid_d;
    logic [15:0] exec_instr_q;
    logic [31:0] dout_q, dout_d;
    logic [31:0] rx_head [NSM];

    always_comb begin
        restart_d    = (action == ActRst) ? din[NSM-1:0] : '0;
        exec_valid_d = (action == ActExec) ? sel : '0;
        dout_d       = dout_q;
        if (action == ActPop && !rx_empty[mindex]) dout_d = rx_head[mindex];
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            for (int k = 0; k < NSM; k++) begin
                clkdiv_q[k]    <= 32'h0001_0000;
                pinctrl_q[k]   <= '0;
                execctrl_q[k]  <= '0;
                shiftctrl_q[k] <= '0;
            end
            en_mask_q    <= '0;
            restart_q    <= '0;
            exec_valid_q <= '0;
            exec_instr_q <= '0;
            dout_q       <= '0;
        end else begin
            for (int k = 0; k < NSM; k++) begin
                if (sel[k]) begin
                    if (action == ActClk)   clkdiv_q[k]    <= din;
                    if (action == ActPin)   pinctrl_q[k]   <= din;
                    if (action == ActExecC) execctrl_q[k]  <= din;
                    if (action == ActShift) shiftctrl_q[k] <= din;
                end
            end
            if (action == ActEn)   en_mask_q    <= din[NSM-1:0];
            if (action == ActExec) exec_instr_q <= din[15:0];
            restart_q    <= restart_d;
            exec_valid_q <= exec_valid_d;
            dout_q       <= dout_d;
        end
    end

    assign en_mask    = en_mask_q;
    assign restart    = restart_q;
    assign exec_valid = exec_valid_q;
    assign exec_instr = exec_instr_q;
    assign dout       = dout_q;

    for (genvar i = 0; i < NSM; i++) begin : g_sm
        logic [31:0]   tx_mem_q [FIFO_DEPTH];
        logic [31:0]   rx_mem_q [FIFO_DEPTH];
        logic [PW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
        logic          tx_full_w, tx_empty_w, rx_full_w, rx_empty_w;
        logic          tx_push, tx_pop, rx_push, rx_pop;

        assign tx_empty_w = (tx_wptr_q == tx_rptr_q);
        assign tx_full_w  = (tx_wptr_q[AW] != tx_rptr_q[AW]) &&
                            (tx_wptr_q[AW-1:0] == tx_rptr_q[AW-1:0]);
        assign rx_empty_w = (rx_wptr_q == rx_rptr_q);
        assign rx_full_w  = (rx_wptr_q[AW] != rx_rptr_q[AW]) &&
                            (rx_wptr_q[AW-1:0] == rx_rptr_q[AW-1:0]);

        // A push into a full FIFO only lands when a pop frees a slot in the same cycle.
        assign tx_pop  = sm_pull[i] && !tx_empty_w;
        assign tx_push = (action == ActPush) && sel[i] && (!tx_full_w || tx_pop);
        assign rx_pop  = (action == ActPop) && sel[i] && !rx_empty_w;
        assign rx_push = sm_push[i] && (!rx_full_w || rx_pop);

        always_ff @(posedge clk_25mhz) begin
            if (reset) begin
                tx_wptr_q <= '0;
                tx_rptr_q <= '0;
                rx_wptr_q <= '0;
                rx_rptr_q <= '0;
            end else begin
                if (tx_push) tx_wptr_q <= tx_wptr_q + PW'(1);
                if (tx_pop)  tx_rptr_q <= tx_rptr_q + PW'(1);
                if (rx_push) rx_wptr_q <= rx_wptr_q + PW'(1);
                if (rx_pop)  rx_rptr_q <= rx_rptr_q + PW'(1);
            end
        end

        always_ff @(posedge clk_25mhz) begin
            if (tx_push) tx_mem_q[tx_wptr_q[AW-1:0]] <= din;
            if (rx_push) rx_mem_q[rx_wptr_q[AW-1:0]] <= sm_rxdata[32*i +: 32];
        end

        assign rx_head[i]              = rx_mem_q[rx_rptr_q[AW-1:0]];
        assign tx_full[i]              = tx_full_w;
        assign sm_txempty[i]           = tx_empty_w;
        assign rx_empty[i]             = rx_empty_w;
        assign sm_rxfull[i]            = rx_full_w;
        assign sm_txdata[32*i +: 32]   = tx_mem_q[tx_rptr_q[AW-1:0]];
        assign imem_rdata[16*i +: 16]  = imem_q[imem_raddr[IW*i +: IW]];
        assign sm_clkdiv[32*i +: 32]   = clkdiv_q[i];
        assign sm_pinctrl[32*i +: 32]  = pinctrl_q[i];
        assign sm_execctrl[32*i +: 32] = execctrl_q[i];
        assign sm_shiftctrl[32*i +: 32] = shiftctrl_q[i];
    end

endmodule
